// File: rtl/udma_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : udma_uart_pkg
//  Purpose  : Shared types and constants for the uDMA UART oversampling
//             receiver: rx FSM state encoding, oversample rate, majority
//             sample positions and data-width encoding helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package udma_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned OS_RATE = 16;

  // Sample positions within a bit used for the 2-of-3 vote; the decision
  // is taken on the tick of the last one.
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  function automatic logic [3:0] bits_to_count(input logic [1:0] bits);
    logic [3:0] cnt;
    cnt = 4'd8;
    case (bits)
      BITS_5:  cnt = 4'd5;
      BITS_6:  cnt = 4'd6;
      BITS_7:  cnt = 4'd7;
      default: cnt = 4'd8;
    endcase
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udma_uart_os_tick.sv
`default_nettype none
// ============================================================================
//  Module   : udma_uart_os_tick
//  Purpose  : Oversample tick divider. Counts 0..div_i and asserts tick_o in
//             the cycle where the count equals div_i, then wraps to 0.
//  Ports    : periph_clk_i / rstn_i - clock, async active-low reset
//             en_i      - counter held at 0 while low
//             restart_i - force the count back to 0 (start-edge alignment)
//             div_i     - terminal count
//             tick_o    - one-cycle oversample tick
//  Revision : 1.0 - initial release
// ============================================================================
module udma_uart_os_tick
  import udma_uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 periph_clk_i,
  input  logic                 rstn_i,
  input  logic                 en_i,
  input  logic                 restart_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic                 wrap;

  always_comb begin
    // >= rather than == so a lowered divisor can never strand the counter
    // above its terminal value.
    wrap   = (cnt_q >= div_i);
    tick_o = en_i & ~restart_i & wrap;
    cnt_d  = cnt_q + 1'b1;
    if (!en_i || restart_i || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/udma_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module   : udma_uart_rx_os
//  Purpose  : 16x oversampling UART receiver with 2-of-3 majority bit
//             decisions, valid/ready byte output, sticky parity/framing/
//             overrun errors and a one-cycle break pulse.
//  Ports    : periph_clk_i, rstn_i        - clock, async active-low reset
//             rx_i                        - asynchronous serial line
//             cfg_*                       - enable, divider, frame format
//             rx_data_o/rx_valid_o/rx_ready_i - received char handshake
//             busy_o                      - frame in progress
//             err_parity_o/err_frame_o/err_overrun_o - sticky errors
//             break_o                     - break detected pulse
//             err_clr_i                   - clears sticky errors
//  Revision : 1.0 - initial release
// ============================================================================
module udma_uart_rx_os #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned OS_RATE   = 16
) (
  input  logic                 periph_clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_parity_odd_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_stop_bits_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 busy_o,
  output logic                 err_parity_o,
  output logic                 err_frame_o,
  output logic                 err_overrun_o,
  output logic                 break_o,
  input  logic                 err_clr_i
);
  import udma_uart_pkg::*;

  localparam logic [3:0] SAMP_LAST = 4'(OS_RATE - 1);

  // Input synchroniser plus one delayed copy for edge detection.
  logic rx_sync1_q, rx_sync2_q, rx_prev_q;

  rx_state_e            state_q, state_d;
  logic [3:0]           samp_q, samp_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 s7_q, s7_d, s8_q, s8_d;
  logic [7:0]           shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 brk_wait_q, brk_wait_d;

  // Per-frame configuration captured at the start edge.
  logic [1:0]           bits_q, bits_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 err_par_q, err_par_d;
  logic                 err_frm_q, err_frm_d;
  logic                 err_ovr_q, err_ovr_d;
  logic                 break_q, break_d;

  logic start_edge, tick, maj, restart;
  logic done, done_ferr, brk_evt, ovr_set;

  assign start_edge = rx_prev_q & ~rx_sync2_q;
  assign maj        = (s7_q & s8_q) | (s7_q & rx_sync2_q) | (s8_q & rx_sync2_q);

  udma_uart_os_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick (
    .periph_clk_i (periph_clk_i),
    .rstn_i       (rstn_i),
    .en_i         (cfg_en_i),
    .restart_i    (restart),
    .div_i        (div_q),
    .tick_o       (tick)
  );

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    // After a break the line must return high before a start is accepted.
    brk_wait_d = brk_wait_q & ~rx_sync2_q;
    bits_d     = bits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    restart    = 1'b0;
    done       = 1'b0;
    done_ferr  = 1'b0;
    brk_evt    = 1'b0;

    if (!cfg_en_i) begin
      state_d = RX_IDLE;
    end else if (state_q == RX_IDLE) begin
      if (start_edge && !brk_wait_q) begin
        state_d   = RX_START;
        samp_d    = '0;
        bit_cnt_d = '0;
        shift_d   = '0;
        par_bit_d = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        restart   = 1'b1;
        bits_d    = cfg_bits_i;
        par_en_d  = cfg_parity_en_i;
        par_odd_d = cfg_parity_odd_i;
        stop2_d   = cfg_stop_bits_i;
        div_d     = cfg_div_i;
      end
    end else if (tick) begin
      samp_d = (samp_q == SAMP_LAST) ? 4'd0 : samp_q + 4'd1;
      if (samp_q == SAMPLE_A) s7_d = rx_sync2_q;
      if (samp_q == SAMPLE_B) s8_d = rx_sync2_q;
      if (samp_q == SAMPLE_C) begin
        case (state_q)
          RX_START: begin
            bit_cnt_d = '0;
            state_d   = maj ? RX_IDLE : RX_DATA;
          end
          RX_DATA: begin
            shift_d[bit_cnt_q] = maj;
            if ({1'b0, bit_cnt_q} == bits_to_count(bits_q) - 4'd1) begin
              bit_cnt_d = '0;
              state_d   = par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          RX_PARITY: begin
            par_bit_d = maj;
            if (maj != (^shift_q ^ par_odd_q)) par_err_d = 1'b1;
            state_d = RX_STOP;
          end
          RX_STOP: begin
            if (bit_cnt_q == 3'd0 && !maj && shift_q == 8'h00 &&
                !(par_en_q && par_bit_q)) begin
              brk_evt    = 1'b1;
              brk_wait_d = 1'b1;
              state_d    = RX_IDLE;
            end else if (bit_cnt_q == 3'd0 && stop2_q) begin
              frm_err_d = frm_err_q | ~maj;
              bit_cnt_d = 3'd1;
            end else begin
              // Leave mid-bit so the next start edge is seen promptly.
              done      = 1'b1;
              done_ferr = frm_err_q | ~maj;
              state_d   = RX_IDLE;
            end
          end
          default: state_d = RX_IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Delivery and sticky errors
  // --------------------------------------------------------------------------
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready_i;
    ovr_set    = 1'b0;
    if (done) begin
      if (rx_valid_q && !rx_ready_i) begin
        ovr_set = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end
    // A new error in the same cycle as a clear still sets the flag.
    err_par_d = (err_par_q & ~err_clr_i) | (done & par_err_q);
    err_frm_d = (err_frm_q & ~err_clr_i) | (done & done_ferr);
    err_ovr_d = (err_ovr_q & ~err_clr_i) | ovr_set;
    break_d   = brk_evt;
  end

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= RX_IDLE;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      brk_wait_q <= 1'b0;
      bits_q     <= BITS_8;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      div_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      rx_sync1_q <= rx_i;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      state_q    <= state_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      brk_wait_q <= brk_wait_d;
      bits_q     <= bits_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
      err_ovr_q  <= err_ovr_d;
      break_q    <= break_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign busy_o        = (state_q != RX_IDLE);
  assign err_parity_o  = err_par_q;
  assign err_frame_o   = err_frm_q;
  assign err_overrun_o = err_ovr_q;
  assign break_o       = break_q;

endmodule
`default_nettype wire
